// File: rtl/pipelined_sqrt_css_28bit_sub.sv
// 28-bit pipelined subtractor: {b_out, diff} = a - b - b_in.
// Computed as a + ~b + ~b_in on a square-root carry-select datapath
// (segments 2,2,3,4,5,6,6). Borrow out is the inverted final carry.
// Three register stages with one shared advance enable.
//
// Handshake: a beat moves on a side when valid && ready are both high
// at a rising edge. in_ready = en = !(out_valid && !out_ready), so it
// depends only on the output side. While en is low every stage holds,
// bubbles included. Bubbles are never collapsed.
module pipelined_sqrt_css_28bit_sub #(
   parameter int WIDTH = 28,
   parameter int LAT   = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             zero
);

   // Segment lower bounds; the last entry is the total width.
   localparam int SEG_LO [0:7] = '{0, 2, 4, 7, 11, 16, 22, 28};

   logic en;

   // Stage 1: operand capture
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             nb_q, nb_d;
   logic             v1_q, v1_d;

   // Stage 2: selected sum and carry
   logic [WIDTH-1:0] diff2_q, diff2_d;
   logic             c2_q, c2_d;
   logic             v2_q, v2_d;

   // Stage 3: outputs
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             b_out_q, b_out_d;
   logic             zero_q, zero_d;
   logic             out_valid_q, out_valid_d;

   // Combinational datapath between stage 1 and stage 2
   logic [WIDTH-1:0] nb_w;
   logic [WIDTH-1:0] sum_c;
   logic             r0_c, r1_c, c1_c, c_lo_c;
   logic             c_out_c;

   // Advance enable: stall only when a result is held and not taken.
   assign en        = !(out_valid_q && !out_ready);
   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign b_out     = b_out_q;
   assign zero      = zero_q;

   assign nb_w = ~b_q;

   // Low two bits: plain ripple seeded by the inverted borrow in.
   always_comb begin
      r0_c   = a_q[0] ^ nb_w[0] ^ nb_q;
      c1_c   = (a_q[0] & nb_w[0]) | (nb_q & (a_q[0] ^ nb_w[0]));
      r1_c   = a_q[1] ^ nb_w[1] ^ c1_c;
      c_lo_c = (a_q[1] & nb_w[1]) | (c1_c & (a_q[1] ^ nb_w[1]));
   end

   assign sum_c[1:0] = {r1_c, r0_c};

   // Upper segments: both carry-in cases precomputed, picked by the
   // carry rippling out of the previous segment.
   for (genvar gi = 1; gi < 7; gi++) begin : g_seg
      localparam int LO = SEG_LO[gi];
      localparam int W  = SEG_LO[gi+1] - SEG_LO[gi];
      logic [W:0] s0;
      logic [W:0] s1;
      logic       cin;
      logic       cout;
      assign s0 = {1'b0, a_q[LO +: W]} + {1'b0, nb_w[LO +: W]};
      assign s1 = {1'b0, a_q[LO +: W]} + {1'b0, nb_w[LO +: W]} + {{W{1'b0}}, 1'b1};
      if (gi == 1) begin : g_first
         assign cin = c_lo_c;
      end else begin : g_next
         assign cin = g_seg[gi-1].cout;
      end
      assign cout          = cin ? s1[W] : s0[W];
      assign sum_c[LO +: W] = cin ? s1[W-1:0] : s0[W-1:0];
   end

   assign c_out_c = g_seg[6].cout;

   // Next-state for all three stages; everything holds when en is low.
   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      nb_d        = nb_q;
      v1_d        = v1_q;
      diff2_d     = diff2_q;
      c2_d        = c2_q;
      v2_d        = v2_q;
      diff_d      = diff_q;
      b_out_d     = b_out_q;
      zero_d      = zero_q;
      out_valid_d = out_valid_q;
      if (en) begin
         a_d         = a;
         b_d         = b;
         nb_d        = ~b_in;
         v1_d        = in_valid;
         diff2_d     = sum_c;
         c2_d        = c_out_c;
         v2_d        = v1_q;
         diff_d      = diff2_q;
         b_out_d     = ~c2_q;
         zero_d      = (diff2_q == '0);
         out_valid_d = v2_q;
      end
   end

   // Pipeline registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         a_q         <= '0;
         b_q         <= '0;
         nb_q        <= 1'b0;
         v1_q        <= 1'b0;
         diff2_q     <= '0;
         c2_q        <= 1'b0;
         v2_q        <= 1'b0;
         diff_q      <= '0;
         b_out_q     <= 1'b0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         nb_q        <= nb_d;
         v1_q        <= v1_d;
         diff2_q     <= diff2_d;
         c2_q        <= c2_d;
         v2_q        <= v2_d;
         diff_q      <= diff_d;
         b_out_q     <= b_out_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_pipelined_sqrt_css_28bit_sub.sv
// Bench for pipelined_sqrt_css_28bit_sub: reset, directed vectors with
// hand-computed results, back-to-back streaming and random backpressure.
module tb_pipelined_sqrt_css_28bit_sub;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [27:0] a, b;
   logic        b_in;
   logic        out_valid;
   logic        out_ready;
   logic [27:0] diff;
   logic        b_out;
   logic        zero;

   always #5 clk = ~clk;

   pipelined_sqrt_css_28bit_sub dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .b_out     (b_out),
      .zero      (zero)
   );

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   // Golden model: 29-bit two's complement difference; bit 28 is the borrow.
   function automatic logic [28:0] model(input logic [27:0] ma, input logic [27:0] mb, input logic mbin);
      logic [28:0] r;
      r = {1'b0, ma} - {1'b0, mb} - {28'b0, mbin};
      return r;
   endfunction

   // ---------------- scoreboard / monitor ----------------
   logic [28:0] exp_q[$];
   logic        mon_en = 1'b0;
   int          cyc = 0;
   int          first_out, last_out, n_out;
   logic        prev_stall = 1'b0;
   logic [27:0] prev_diff;
   logic        prev_bout, prev_zero;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (mon_en) begin
         logic [28:0] e;
         chk("in_ready_rule", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
         if (prev_stall) begin
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_diff", {4'b0, diff}, {4'b0, prev_diff});
            chk("stall_bout", {31'b0, b_out}, {31'b0, prev_bout});
            chk("stall_zero", {31'b0, zero}, {31'b0, prev_zero});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", {4'b0, diff}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("stream_diff", {4'b0, diff}, {4'b0, e[27:0]});
               chk("stream_bout", {31'b0, b_out}, {31'b0, e[28]});
               chk("stream_zero", {31'b0, zero}, {31'b0, (e[27:0] == 28'd0)});
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            n_out++;
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, b_in));
         prev_stall = out_valid && !out_ready;
         prev_diff  = diff;
         prev_bout  = b_out;
         prev_zero  = zero;
      end
   end

   // ---------------- driver tasks ----------------
   // Single beat with out_ready held high; checks the three-edge latency.
   task automatic run_one(input string tag, input logic [27:0] ta, input logic [27:0] tb,
                          input logic tbin, input logic [27:0] ed, input logic eb, input logic ez);
      a = ta; b = tb; b_in = tbin; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      chk({tag, "_lat2"}, {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_diff"}, {4'b0, diff}, {4'b0, ed});
      chk({tag, "_bout"}, {31'b0, b_out}, {31'b0, eb});
      chk({tag, "_zero"}, {31'b0, zero}, {31'b0, ez});
      @(negedge clk);
      chk({tag, "_gone"}, {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic new_operands();
      a    = 28'($urandom);
      b    = ($urandom_range(0, 3) == 0) ? a : 28'($urandom);
      b_in = 1'($urandom_range(0, 1));
   endtask

   // Sends n beats with continuous in_valid; out_ready low with pct_low %.
   task automatic run_stream(input string tag, input int n, input int pct_low, output int first_acc);
      int   sent  = 0;
      int   guard = 0;
      logic acc;
      first_acc = -1;
      first_out = -1; last_out = -1; n_out = 0;
      new_operands();
      in_valid  = 1'b1;
      out_ready = ($urandom_range(0, 99) >= pct_low);
      while (sent < n && guard < 20 * n) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc) begin
            if (sent == 0) first_acc = cyc;
            sent++;
         end
         @(posedge clk); #1;
         guard++;
         out_ready = ($urandom_range(0, 99) >= pct_low);
         if (acc) begin
            if (sent < n) new_operands();
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk({tag, "_send_timeout"}, sent, n);
      out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      chk({tag, "_drain_timeout"}, exp_q.size(), 0);
      chk({tag, "_count"}, n_out, n);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int fa;
      rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; b_in = 1'b0;
      first_out = -1; last_out = -1; n_out = 0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_diff", {4'b0, diff}, 32'd0);
      chk("rst_bout", {31'b0, b_out}, 32'd0);
      chk("rst_zero", {31'b0, zero}, 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // Mid-stream reset: three beats enter while the sink is stalled.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 28'(100 + i); b = 28'd1; b_in = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("midrst_stalled", {31'b0, in_ready}, 32'd0);
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_diff", {4'b0, diff}, 32'd0);
      chk("midrst_bout", {31'b0, b_out}, 32'd0);
      chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midrst_no_ghost", {31'b0, out_valid}, 32'd0);
      end
      @(posedge clk); #1;

      // Directed vectors.
      run_one("basic",  28'h000_0010, 28'h000_0003,  1'b0, 28'h000_000D, 1'b0, 1'b0);
      run_one("wrap",   28'h000_0000, 28'h0FF_FFFF_F, 1'b1, 28'h000_0000, 1'b1, 1'b1);
      run_one("equal",  28'h000_0005, 28'h000_0005,  1'b0, 28'h000_0000, 1'b0, 1'b1);
      run_one("segbnd", 28'h040_0000, 28'h000_0001,  1'b0, 28'h03F_FFFF, 1'b0, 1'b0);
      run_one("neg1",   28'h000_0000, 28'h000_0001,  1'b0, 28'hFFF_FFFF, 1'b1, 1'b0);
      run_one("binonly",28'h000_0000, 28'h000_0000,  1'b1, 28'hFFF_FFFF, 1'b1, 1'b0);
      run_one("maxbin", 28'hFFF_FFFF, 28'h000_0000,  1'b1, 28'hFFF_FFFE, 1'b0, 1'b0);
      run_one("top",    28'h800_0000, 28'h7FF_FFFF,  1'b0, 28'h000_0001, 1'b0, 1'b0);

      // Streaming, no backpressure.
      exp_q.delete();
      prev_stall = 1'b0;
      mon_en = 1'b1;
      run_stream("stream", 100, 0, fa);
      chk("stream_first_latency", first_out - fa, 3);
      chk("stream_back_to_back", last_out - first_out, 99);

      // Random backpressure, ~30% of cycles with out_ready low.
      run_stream("bp", 200, 30, fa);
      mon_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
